seven_segment_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-enable hex seven-segment digits.

---
 rtl/seven_segment_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed hex seven-segment driver. Each digit slot opens with a dead time,
// and new values are committed only at frame boundaries so a frame never shows mixed data.
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 24000,
    parameter int DEAD_CYCLES    = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_tick
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0]      DIG_LAST = DIG_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0]      DEAD_END = DIV_W'(DEAD_CYCLES);
    localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] EN_OFF   = {NUM_DIGITS{EN_ACTIVE_LOW}};

    // Active-high glyphs, bit0 = segment a.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;  4'hF: decode = 7'h71;
            default: decode = 7'h00;
        endcase
    endfunction

    logic [DIV_W-1:0]        div_q, div_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic [4*NUM_DIGITS-1:0] disp_value_q, disp_value_d;
    logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    frame_tick_q;
    logic                    boundary;

    assign boundary = (div_q == DIV_LAST) && (digit_q == DIG_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: the buffered data registers are reset as well, so a reset mid-frame
        // cannot leak stale pending data into the first committed frame.
        if (!reset) begin
            div_q        <= '0;
            digit_q      <= '0;
            pending_q    <= 1'b0;
            pend_value_q <= '0;
            pend_blank_q <= '0;
            disp_value_q <= '0;
            disp_blank_q <= '1;
            seg_q        <= SEG_OFF;
            en_q         <= EN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // pre-edge values regardless of statement order.
            div_q        <= div_d;
            digit_q      <= digit_d;
            pending_q    <= pending_d;
            pend_value_q <= pend_value_d;
            pend_blank_q <= pend_blank_d;
            disp_value_q <= disp_value_d;
            disp_blank_q <= disp_blank_d;
            seg_q        <= seg_d;
            en_q         <= en_d;
            frame_tick_q <= boundary;
        end
    end

    // Next-state: scan counters and the double buffer.
    always_comb begin
        // NOTE: defaults first, so no path through this block leaves a signal unassigned.
        div_d        = div_q + 1'b1;
        digit_d      = digit_q;
        pending_d    = pending_q;
        pend_value_d = pend_value_q;
        pend_blank_d = pend_blank_q;
        disp_value_d = disp_value_q;
        disp_blank_d = disp_blank_q;

        if (div_q == DIV_LAST) begin
            div_d   = '0;
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
        end

        if (boundary && pending_q) begin
            disp_value_d = pend_value_q;
            disp_blank_d = pend_blank_q;
            pending_d    = 1'b0;
        end

        // A load on the boundary cycle lands after the commit and waits a frame.
        if (load) begin
            pend_value_d = value_in;
            pend_blank_d = blank_in;
            pending_d    = 1'b1;
        end
    end

    // Output: decode the current slot, one cycle ahead of the pins.
    always_comb begin
        logic [3:0]            sel_value;
        logic                  sel_blank;
        logic [NUM_DIGITS-1:0] onehot;

        sel_value = 4'h0;
        sel_blank = 1'b1;
        onehot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_q == DIG_W'(k)) begin
                sel_value = disp_value_q[4*k +: 4];
                sel_blank = disp_blank_q[k];
                onehot[k] = 1'b1;
            end
        end

        if (div_q < DEAD_END) begin
            seg_d = SEG_OFF;
            en_d  = EN_OFF;
        end else begin
            seg_d = sel_blank ? SEG_OFF : (decode(sel_value) ^ SEG_OFF);
            en_d  = onehot ^ EN_OFF;
        end
    end

    assign seg        = seg_q;
    assign digit_en   = en_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Directed bench for seven_segment_scan_driver: a cycle-count reference model checked
// every cycle, plus literal expectations for decode, scan order, buffering and reset.
module tb_seven_segment_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int DC = 1;
    localparam int FRAME = ND * RD;

    // Active-high glyphs 0..F, index 0 in the low bits.
    localparam logic [111:0] HI_TAB = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                       7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    // Pin-level (inverted) glyphs 0..F, written out by hand.
    localparam logic [111:0] PIN_TAB = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  blank_in;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seven_segment_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC),
        .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .value_in(value_in), .blank_in(blank_in),
        .seg(seg), .digit_en(digit_en), .frame_tick(frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [111:0] t;
        t = HI_TAB;
        return t[int'(v)*7 +: 7];
    endfunction

    function automatic logic [6:0] pin_lit(input int v);
        logic [111:0] t;
        t = PIN_TAB;
        return t[v*7 +: 7];
    endfunction

    // Reference model: position in the scan derived from cycles since reset.
    bit          m_valid = 1'b0;
    int          m_cyc;
    bit          m_pend;
    logic [15:0] m_pend_val, m_disp_val;
    logic [3:0]  m_pend_blank, m_disp_blank;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_en;
    logic        exp_tick;

    always @(posedge clk) begin
        int          pos, dig;
        bit          bnd, t_pend;
        logic [15:0] t_dval;
        logic [3:0]  t_dblank;
        if (!reset) begin
            m_valid      <= 1'b1;
            m_cyc        <= 0;
            m_pend       <= 1'b0;
            m_pend_val   <= '0;
            m_pend_blank <= '0;
            m_disp_val   <= '0;
            m_disp_blank <= 4'hF;
            exp_seg      <= 7'h7F;
            exp_en       <= 4'hF;
            exp_tick     <= 1'b0;
        end else begin
            pos = m_cyc % RD;
            dig = (m_cyc / RD) % ND;
            bnd = (m_cyc % FRAME) == FRAME - 1;
            if (pos < DC) begin
                exp_en  <= 4'hF;
                exp_seg <= 7'h7F;
            end else begin
                exp_en  <= ~(4'b0001 << dig);
                exp_seg <= m_disp_blank[dig] ? 7'h7F : ~glyph(m_disp_val[dig*4 +: 4]);
            end
            exp_tick <= bnd;
            t_dval   = m_disp_val;
            t_dblank = m_disp_blank;
            t_pend   = m_pend;
            if (bnd && m_pend) begin
                t_dval   = m_pend_val;
                t_dblank = m_pend_blank;
                t_pend   = 1'b0;
            end
            if (load) begin
                m_pend_val   <= value_in;
                m_pend_blank <= blank_in;
                t_pend       = 1'b1;
            end
            m_disp_val   <= t_dval;
            m_disp_blank <= t_dblank;
            m_pend       <= t_pend;
            m_cyc        <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_seg", {25'd0, seg}, {25'd0, exp_seg});
            check("model_digit_en", {28'd0, digit_en}, {28'd0, exp_en});
            check("model_frame_tick", {31'd0, frame_tick}, {31'd0, exp_tick});
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] b);
        @(negedge clk);
        load     = 1'b1;
        value_in = v;
        blank_in = b;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_tick_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    // Count enabled cycles over one frame that show the given pin pattern.
    task automatic count_frame(input logic [6:0] pat, output int hits);
        hits = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (digit_en != 4'hF && seg == pat) hits++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          hits, torn;
        logic [27:0] lit3;
        logic [6:0]  s_exp;
        logic [3:0]  e_exp;

        reset    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        blank_in = '0;

        // Reset state, then blank scanning until something commits.
        repeat (3) @(negedge clk);
        check("reset_seg", {25'd0, seg}, 32'h7F);
        check("reset_en", {28'd0, digit_en}, 32'hF);
        check("reset_tick", {31'd0, frame_tick}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_dead_en", {28'd0, digit_en}, 32'hF);
        @(negedge clk);
        check("post_reset_d0_en", {28'd0, digit_en}, 32'hE);
        check("post_reset_blank_seg", {25'd0, seg}, 32'h7F);

        // Decode every nibble on digit 0.
        for (int v = 0; v < 16; v++) begin
            do_load(16'(v), 4'b1110);
            wait_tick("decode");
            wait_tick("decode");
            @(negedge clk);
            @(negedge clk);
            check($sformatf("decode_en_%0h", v), {28'd0, digit_en}, 32'hE);
            check($sformatf("decode_seg_%0h", v), {25'd0, seg}, {25'd0, pin_lit(v)});
        end

        // Scan order and slot timing for 1234.
        do_load(16'h1234, 4'h0);
        wait_tick("scan");
        wait_tick("scan");
        lit3 = {7'h79, 7'h24, 7'h30, 7'h19};
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            e_exp = (i % RD == 0) ? 4'hF : ~(4'b0001 << (i / RD));
            s_exp = (i % RD == 0) ? 7'h7F : lit3[(i / RD)*7 +: 7];
            check($sformatf("scan_en_%0d", i), {28'd0, digit_en}, {28'd0, e_exp});
            check($sformatf("scan_seg_%0d", i), {25'd0, seg}, {25'd0, s_exp});
            check($sformatf("scan_tick_%0d", i), {31'd0, frame_tick}, (i == FRAME - 1) ? 32'd1 : 32'd0);
        end

        // Tear-free: mid-frame load stays invisible until the next boundary.
        repeat (7) @(negedge clk);
        do_load(16'hAAAA, 4'h0);
        torn = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) break;
            if (digit_en != 4'hF && seg == 7'h08) torn++;
        end
        check("tearfree_old_frame", torn, 32'd0);
        count_frame(7'h08, hits);
        check("tearfree_new_frame", hits, 32'd12);

        // Two loads in one frame: last wins.
        do_load(16'h1111, 4'h0);
        do_load(16'h2222, 4'h0);
        wait_tick("collide");
        hits = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (digit_en != 4'hF && seg == 7'h24) hits++;
            if (i == FRAME - 2) begin
                load     = 1'b1;
                value_in = 16'h3333;
                blank_in = 4'h0;
            end
            if (i == FRAME - 1) begin
                load = 1'b0;
                check("boundary_load_tick", {31'd0, frame_tick}, 32'd1);
            end
        end
        check("last_write_wins", hits, 32'd12);
        // Load on the boundary cycle waits one full frame.
        count_frame(7'h24, hits);
        check("boundary_load_deferred", hits, 32'd12);
        count_frame(7'h30, hits);
        check("boundary_load_shown", hits, 32'd12);

        // Reset mid-frame discards pending data.
        repeat (6) @(negedge clk);
        do_load(16'h5555, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_seg", {25'd0, seg}, 32'h7F);
        check("midreset_en", {28'd0, digit_en}, 32'hF);
        check("midreset_tick", {31'd0, frame_tick}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_restart_dead", {28'd0, digit_en}, 32'hF);
        @(negedge clk);
        check("midreset_restart_d0", {28'd0, digit_en}, 32'hE);
        wait_tick("midreset");
        wait_tick("midreset");
        repeat (2) @(negedge clk);
        check("midreset_pending_dropped_en", {28'd0, digit_en}, 32'hE);
        check("midreset_pending_dropped_seg", {25'd0, seg}, 32'h7F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
